// File: rtl/keypad_defs.sv
// Shared definitions for the keypad scanner: FSM states and event layout.
// An event word is {release, code}; release sits just above the key code.
package keypad_defs;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        EVAL = 2'd1,
        EMIT = 2'd2
    } scan_state_t;

    function automatic int code_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    function automatic int evt_width(input int rows, input int cols);
        return code_width(rows, cols) + 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO with a registered empty flag.
// A push into a full FIFO succeeds only when a pop frees a slot that cycle.
module key_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             empty_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = count_q == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty_q;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_d;
            empty_q <= count_d == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= push_data;
    end

    // Head is forced to zero while empty so stale entries never show.
    assign pop_data = empty_q ? '0 : mem[rd_q];
    assign valid    = !empty_q;
    assign empty    = empty_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: row scan, whole-frame debounce, press/release
// event generation into a FWFT FIFO drained by the CPU.
module keypad_matrix_scanner
    import keypad_defs::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [COLS-1:0]                 col_in,
    output logic [ROWS-1:0]                 row_out,
    output logic                            rd_valid,
    output logic [$clog2(ROWS*COLS)-1:0]    rd_code,
    output logic                            rd_release,
    input  logic                            rd_en,
    output logic                            int_n,
    output logic                            overflow,
    input  logic                            ovf_clr
);

    localparam int N      = ROWS * COLS;
    localparam int CODE_W = code_width(ROWS, COLS);
    localparam int EVT_W  = evt_width(ROWS, COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int SW     = $clog2(SETTLE_CYCLES);
    localparam int STW    = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [RW-1:0]     LAST_ROW    = RW'(ROWS - 1);
    localparam logic [SW-1:0]     LAST_SETTLE = SW'(SETTLE_CYCLES - 1);
    localparam logic [CODE_W-1:0] LAST_KEY    = CODE_W'(N - 1);
    localparam logic [STW-1:0]    DEB_MAX     = STW'(DEBOUNCE_FRAMES);

    scan_state_t       state_q;
    scan_state_t       state_d;
    logic [RW-1:0]     row_q;
    logic [SW-1:0]     settle_q;
    logic [CODE_W-1:0] k_q;
    logic [STW-1:0]    stable_q;
    logic [STW-1:0]    stable_inc;
    logic [N-1:0]      frame_q;
    logic [N-1:0]      cand_q;
    logic [N-1:0]      deb_q;
    logic              last_settle;
    logic              last_row;
    logic              last_key;
    logic              accept;
    logic              push;
    logic [EVT_W-1:0]  push_evt;
    logic [EVT_W-1:0]  head;
    logic              drop;
    logic              overflow_q;

    assign last_settle = settle_q == LAST_SETTLE;
    assign last_row    = row_q == LAST_ROW;
    assign last_key    = k_q == LAST_KEY;
    assign stable_inc  = (stable_q == DEB_MAX) ? stable_q : stable_q + 1'b1;
    assign accept      = (frame_q == cand_q) &&
                         (stable_inc == DEB_MAX) &&
                         (cand_q != deb_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SCAN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN:    if (last_settle && last_row) state_d = EVAL;
            EVAL:    state_d = accept ? EMIT : SCAN;
            EMIT:    if (last_key) state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        row_out  = '0;
        push     = 1'b0;
        push_evt = '0;
        unique case (state_q)
            SCAN: row_out[row_q] = 1'b1;
            EMIT: begin
                row_out[0] = 1'b1;
                push       = cand_q[k_q] != deb_q[k_q];
                push_evt   = {~cand_q[k_q], k_q};
            end
            default: row_out[0] = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q    <= '0;
            settle_q <= '0;
            k_q      <= '0;
            stable_q <= '0;
            frame_q  <= '0;
            cand_q   <= '0;
            deb_q    <= '0;
        end else begin
            unique case (state_q)
                SCAN: begin
                    if (last_settle) begin
                        settle_q <= '0;
                        row_q    <= last_row ? '0 : row_q + 1'b1;
                        for (int r = 0; r < ROWS; r++) begin
                            if (row_q == RW'(r))
                                frame_q[r*COLS +: COLS] <= col_in;
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                EVAL: begin
                    k_q <= '0;
                    // Any difference restarts the stability count.
                    if (frame_q != cand_q) begin
                        cand_q   <= frame_q;
                        stable_q <= STW'(1);
                    end else begin
                        stable_q <= stable_inc;
                    end
                end
                EMIT: begin
                    if (last_key) begin
                        k_q   <= '0;
                        deb_q <= cand_q;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow_q <= 1'b0;
        else if (drop)    overflow_q <= 1'b1;
        else if (ovf_clr) overflow_q <= 1'b0;
    end

    key_event_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_evt),
        .pop       (rd_en),
        .pop_data  (head),
        .valid     (rd_valid),
        .empty     (int_n),
        .drop      (drop)
    );

    assign rd_code    = head[CODE_W-1:0];
    assign rd_release = head[CODE_W];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: physical key-matrix model plus an
// event scoreboard derived from key-set differences.
module tb_keypad_matrix_scanner;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int N    = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [COLS-1:0]  col_in;
    logic [ROWS-1:0]  row_out;
    logic             rd_valid;
    logic [3:0]       rd_code;
    logic             rd_release;
    logic             rd_en = 1'b0;
    logic             int_n;
    logic             overflow;
    logic             ovf_clr = 1'b0;

    logic [N-1:0] keys = '0;
    logic         glitch = 1'b0;
    logic [N-1:0] reported = '0;
    logic [4:0]   expq[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .ROWS            (4),
        .COLS            (4),
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_FRAMES (3),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_in     (col_in),
        .row_out    (row_out),
        .rd_valid   (rd_valid),
        .rd_code    (rd_code),
        .rd_release (rd_release),
        .rd_en      (rd_en),
        .int_n      (int_n),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    // Physical keypad: a closed key shorts its column to the driven row.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_out[r]) col_in = col_in | keys[r*COLS +: COLS];
        end
        if (row_out[0] && glitch) col_in[0] = 1'b1;
    end

    task automatic set_keys(input logic [N-1:0] nk);
        for (int k = 0; k < N; k++) begin
            if (nk[k] != reported[k]) expq.push_back({~nk[k], 4'(k)});
        end
        reported = nk;
        keys = nk;
    endtask

    task automatic drain(input string name);
        int budget;
        logic [4:0] e;
        budget = 400;
        while (expq.size() > 0 && budget > 0) begin
            @(negedge clk);
            rd_en = 1'b0;
            budget--;
            if (rd_valid) begin
                e = expq.pop_front();
                checks++;
                if ({rd_release, rd_code} !== e) begin
                    errors++;
                    $display("FAIL %s event: got rel=%0b code=%0d want rel=%0b code=%0d",
                             name, rd_release, rd_code, e[4], e[3:0]);
                end
                checks++;
                if (int_n !== 1'b0) begin
                    errors++;
                    $display("FAIL %s int_n: got %0b want 0", name, int_n);
                end
                rd_en = 1'b1;
            end
        end
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL %s timeout: %0d events missing want 0", name, expq.size());
            expq.delete();
        end
    endtask

    task automatic quiet(input string name, input int cyc);
        logic seen;
        seen = 1'b0;
        repeat (cyc) begin
            @(negedge clk);
            if (rd_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s quiet: got unexpected event code=%0d want none", name, rd_code);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({row_out, rd_valid, rd_code, rd_release, int_n, overflow} !== {4'b0001, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: got row=%b v=%b c=%0d r=%b i=%b o=%b want row=0001 v=0 c=0 r=0 i=1 o=0",
                     row_out, rd_valid, rd_code, rd_release, int_n, overflow);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_press();
        int lat;
        logic [4:0] e;
        set_keys(16'h0200);
        lat = 0;
        while (!rd_valid && lat < 84) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL press latency: got no event in %0d cycles want <=84", lat);
        end
        e = expq.pop_front();
        checks++;
        if ({rd_release, rd_code} !== e) begin
            errors++;
            $display("FAIL press event: got rel=%0b code=%0d want rel=%0b code=%0d",
                     rd_release, rd_code, e[4], e[3:0]);
        end
        checks++;
        if (int_n !== 1'b0) begin
            errors++;
            $display("FAIL press int_n: got %0b want 0", int_n);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, int_n} !== 2'b01) begin
            errors++;
            $display("FAIL press pop: got valid=%0b int_n=%0b want valid=0 int_n=1", rd_valid, int_n);
        end
        quiet("press_single", 120);
    endtask

    task automatic test_release();
        set_keys(16'h0000);
        drain("release");
        quiet("release_single", 100);
    endtask

    task automatic test_glitch();
        for (int p = 0; p < 6; p++) begin
            glitch = 1'b1;
            repeat ($urandom_range(1, 12)) @(negedge clk);
            glitch = 1'b0;
            repeat ($urandom_range(30, 45)) @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch %0d: got event code=%0d want none", p, rd_code);
            end
        end
        quiet("glitch_tail", 100);
        set_keys(16'h0001);
        drain("glitch_then_hold");
        quiet("glitch_then_hold", 60);
    endtask

    task automatic test_multi();
        set_keys(reported | 16'h8028);
        drain("multi");
        quiet("multi", 60);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            set_keys(N'($urandom_range(0, 65535)));
            drain("random");
            quiet("random", 60);
        end
    endtask

    task automatic test_overflow();
        logic [N-1:0] nk;
        set_keys('0);
        drain("ovf_clear_keys");
        quiet("ovf_clear_keys", 30);
        nk = '0;
        while ($countones(nk) < 5) nk[$urandom_range(0, N-1)] = 1'b1;
        set_keys(nk);
        while (expq.size() > 4) void'(expq.pop_back());
        repeat (150) @(negedge clk);
        checks++;
        if ({overflow, rd_valid} !== 2'b11) begin
            errors++;
            $display("FAIL overflow set: got ovf=%0b valid=%0b want ovf=1 valid=1", overflow, rd_valid);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear: got %0b want 0", overflow);
        end
        drain("overflow_contents");
        quiet("overflow_contents", 60);
    endtask

    task automatic test_reset_mid_emit();
        int t;
        set_keys('0);
        drain("rst_clear_keys");
        quiet("rst_clear_keys", 30);
        set_keys(16'h8001);
        t = 0;
        while (!rd_valid && t < 150) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_emit start: got no event in %0d cycles want event", t);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({row_out, rd_valid, rd_code, rd_release, int_n, overflow} !== {4'b0001, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_emit outputs: got row=%b v=%b c=%0d r=%b i=%b o=%b want row=0001 v=0 c=0 r=0 i=1 o=0",
                     row_out, rd_valid, rd_code, rd_release, int_n, overflow);
        end
        expq.delete();
        reported = '0;
        rst = 1'b1;
        set_keys(16'h8001);
        drain("rst_emit_repress");
        quiet("rst_emit_repress", 60);
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_multi();
        test_random();
        test_overflow();
        test_reset_mid_emit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
